// File: rtl/gamma_lut_loader_if.sv
// ---------------------------------------------------------------------------
// gamma_lut_loader_if
//
// Bundles the signals between the I2C packet decoder / video timing side and
// the gamma LUT loader, and between the loader and the gamma datapath LUT.
//
// Parameters
//   DATA_W        LUT entry width in bits
//   IDX_W         LUT index width; each bank holds 2^IDX_W entries
//
// Signals (direction as seen by the loader, i.e. the slave modport)
//   pkt_sop       in   first byte of a table packet (qualified by pkt_vld)
//   pkt_eop       in   last byte of a table packet (qualified by pkt_vld)
//   pkt_vld       in   pkt_data valid this cycle
//   pkt_data      in   table byte
//   frame_sof     in   video start-of-frame (tvalid & tuser)
//   lut_wr_en     out  LUT write strobe
//   lut_wr_addr   out  {bank, index}
//   lut_wr_data   out  LUT write data
//   rd_bank       out  bank the datapath reads (MSB of its LUT read address)
//   load_busy     out  loader is in LOAD or DRAIN
//   swap_pending  out  a validated table waits for frame_sof
//   load_done     out  one-cycle pulse: packet validated
//   swap_done     out  one-cycle pulse: rd_bank toggled
//   load_err      out  one-cycle pulse: packet rejected
//   err_code      out  cause of last error: 01 short, 10 long, 11 restart
//
// Modports
//   slave   the loader itself
//   master  the environment driving packets and consuming LUT writes
// ---------------------------------------------------------------------------
interface gamma_lut_loader_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
) ();

    logic              pkt_sop;
    logic              pkt_eop;
    logic              pkt_vld;
    logic [DATA_W-1:0] pkt_data;
    logic              frame_sof;

    logic              lut_wr_en;
    logic [IDX_W:0]    lut_wr_addr;
    logic [DATA_W-1:0] lut_wr_data;
    logic              rd_bank;
    logic              load_busy;
    logic              swap_pending;
    logic              load_done;
    logic              swap_done;
    logic              load_err;
    logic [1:0]        err_code;

    modport slave (
        input  pkt_sop, pkt_eop, pkt_vld, pkt_data, frame_sof,
        output lut_wr_en, lut_wr_addr, lut_wr_data, rd_bank, load_busy,
               swap_pending, load_done, swap_done, load_err, err_code
    );

    modport master (
        output pkt_sop, pkt_eop, pkt_vld, pkt_data, frame_sof,
        input  lut_wr_en, lut_wr_addr, lut_wr_data, rd_bank, load_busy,
               swap_pending, load_done, swap_done, load_err, err_code
    );

endinterface

// File: rtl/gamma_lut_loader.sv
// ---------------------------------------------------------------------------
// gamma_lut_loader
//
// Sequences loading of a 2^IDX_W-entry gamma table from the I2C packet stream
// into the inactive (shadow) half of a two-bank LUT, and swaps the bank read
// by the gamma datapath only at a video start-of-frame, so a frame never mixes
// two tables. Malformed packets (short, long, restarted) are rejected and the
// active bank is never touched by a load.
//
// Ports
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   gamma_lut_loader_if.slave: packet input, frame_sof, LUT write port,
//         read-bank select and status/pulse outputs
//
// All outputs are registered or decoded directly from the state register.
// LUT writes, load_done, load_err and err_code appear one cycle after the
// byte that causes them; rd_bank and swap_done one cycle after frame_sof.
// ---------------------------------------------------------------------------
module gamma_lut_loader #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    gamma_lut_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PENDING = 2'd3
    } state_e;

    localparam logic [1:0]       ERR_SHORT   = 2'b01;
    localparam logic [1:0]       ERR_LONG    = 2'b10;
    localparam logic [1:0]       ERR_RESTART = 2'b11;
    localparam logic [IDX_W-1:0] IDX_ZERO    = '0;
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST    = '1;

    // State and counters
    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               rd_bank_q,   rd_bank_d;

    // Registered write port
    logic               wr_en_q,     wr_en_d;
    logic [IDX_W:0]     wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q,   wr_data_d;

    // Status pulses and sticky error code
    logic               load_done_q, load_done_d;
    logic               swap_done_q, swap_done_d;
    logic               load_err_q,  load_err_d;
    logic [1:0]         err_code_q,  err_code_d;

    logic               sop_acc;
    logic               byte_wr;
    logic [IDX_W-1:0]   wr_idx;

    // A start-of-packet byte is honoured in every state; in LOAD it is a restart.
    assign sop_acc = bus.pkt_vld & bus.pkt_sop;

    // Every SOP byte and every byte accepted in LOAD is written to the shadow
    // bank. SOP always lands at index 0, other bytes at the running index.
    assign byte_wr = sop_acc | ((state_q == ST_LOAD) & bus.pkt_vld);
    assign wr_idx  = sop_acc ? IDX_ZERO : idx_q;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default before the case statement so no
    // path leaves it unassigned; that is what keeps this block latch-free.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_bank_d   = rd_bank_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        load_done_d = 1'b0;
        swap_done_d = 1'b0;
        load_err_d  = 1'b0;
        err_code_d  = err_code_q;

        if (byte_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {~rd_bank_q, wr_idx};
            wr_data_d = bus.pkt_data;
        end

        case (state_q)
            ST_IDLE, ST_DRAIN, ST_PENDING: begin
                if (sop_acc) begin
                    // Fresh table. From PENDING this overwrites the waiting
                    // table in the shadow bank: the latest table wins.
                    idx_d = IDX_ONE;
                    if (bus.pkt_eop) begin
                        load_err_d = 1'b1;
                        err_code_d = ERR_SHORT;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d    = ST_LOAD;
                    end
                end else if ((state_q == ST_PENDING) && bus.frame_sof) begin
                    rd_bank_d   = ~rd_bank_q;
                    swap_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if ((state_q == ST_DRAIN) && bus.pkt_vld && bus.pkt_eop) begin
                    // End of an over-long packet: the tail was discarded.
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (bus.pkt_vld) begin
                    if (bus.pkt_sop) begin
                        // Restart: the new byte becomes index 0 of a new table.
                        idx_d      = IDX_ONE;
                        load_err_d = 1'b1;
                        if (bus.pkt_eop) begin
                            err_code_d = ERR_SHORT;
                            state_d    = ST_IDLE;
                        end else begin
                            err_code_d = ERR_RESTART;
                        end
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                        if (bus.pkt_eop) begin
                            if (idx_q == IDX_LAST) begin
                                load_done_d = 1'b1;
                                state_d     = ST_PENDING;
                            end else begin
                                load_err_d = 1'b1;
                                err_code_d = ERR_SHORT;
                                state_d    = ST_IDLE;
                            end
                        end else if (idx_q == IDX_LAST) begin
                            // Table is full but the packet keeps going.
                            load_err_d = 1'b1;
                            err_code_d = ERR_LONG;
                            state_d    = ST_DRAIN;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments so every flop samples the pre-edge value
    // of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rd_bank_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
            swap_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_bank_q   <= rd_bank_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            load_done_q <= load_done_d;
            swap_done_q <= swap_done_d;
            load_err_q  <= load_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.lut_wr_en    = wr_en_q;
    assign bus.lut_wr_addr  = wr_addr_q;
    assign bus.lut_wr_data  = wr_data_q;
    assign bus.rd_bank      = rd_bank_q;
    assign bus.load_done    = load_done_q;
    assign bus.swap_done    = swap_done_q;
    assign bus.load_err     = load_err_q;
    assign bus.err_code     = err_code_q;
    // Decoded from the state register, so swap_pending rises with load_done.
    assign bus.swap_pending = (state_q == ST_PENDING);
    assign bus.load_busy    = (state_q == ST_LOAD) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_gamma_lut_loader.sv
// ---------------------------------------------------------------------------
// tb_gamma_lut_loader
//
// Directed bench for gamma_lut_loader: valid load and swap, short / long /
// restarted packets, replacement while pending, frame_sof coincidences and
// reset in the middle of a load. A negedge monitor mirrors LUT writes into a
// local 512-entry memory and counts writes and pulses; expected values are
// hand-derived constants.
// ---------------------------------------------------------------------------
module tb_gamma_lut_loader;

    logic clk;
    logic rst;

    gamma_lut_loader_if #(.DATA_W(8), .IDX_W(8)) bus ();

    gamma_lut_loader #(.DATA_W(8), .IDX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state: LUT image and event counters.
    logic [7:0] mem [512];
    int wr_cnt = 0, wr_hi_cnt = 0, done_cnt = 0, swap_cnt = 0, err_cnt = 0;
    int b_wr, b_hi, b_done, b_swap, b_err;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.lut_wr_en) begin
                wr_cnt++;
                if (bus.lut_wr_addr[8]) wr_hi_cnt++;
                mem[bus.lut_wr_addr] = bus.lut_wr_data;
            end
            if (bus.load_done) done_cnt++;
            if (bus.swap_done) swap_cnt++;
            if (bus.load_err)  err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_wr = wr_cnt; b_hi = wr_hi_cnt; b_done = done_cnt; b_swap = swap_cnt; b_err = err_cnt;
    endtask

    task automatic idle_inputs();
        bus.pkt_vld = 1'b0; bus.pkt_sop = 1'b0; bus.pkt_eop = 1'b0;
        bus.frame_sof = 1'b0; bus.pkt_data = 8'h00;
    endtask

    // Sends n back-to-back bytes. Data is (index within current table) ^ x.
    // sop2/eop_at/sof_at are byte positions (-1 = never).
    task automatic send(input int n, input bit first_sop, input int sop2, input int eop_at,
                        input int sof_at, input logic [7:0] x, input logic exp_bank);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            if (i == sop2) k = 0;
            bus.pkt_vld   = 1'b1;
            bus.pkt_sop   = ((i == 0) && first_sop) || (i == sop2);
            bus.pkt_eop   = (i == eop_at);
            bus.frame_sof = (i == sof_at);
            bus.pkt_data  = 8'(k) ^ x;
            tick();
            if (i == 0 && first_sop) begin
                check("first_wr_en",   32'(bus.lut_wr_en), 1);
                check("first_wr_addr", 32'(bus.lut_wr_addr), 32'({exp_bank, 8'h00}));
                check("first_wr_data", 32'(bus.lut_wr_data), 32'(x));
            end
            k++;
        end
        idle_inputs();
    endtask

    task automatic pulse_sof();
        bus.frame_sof = 1'b1;
        tick();
        bus.frame_sof = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        // ---- Reset state ----
        check("rst_rd_bank",   32'(bus.rd_bank), 0);
        check("rst_busy",      32'(bus.load_busy), 0);
        check("rst_pending",   32'(bus.swap_pending), 0);
        check("rst_err_code",  32'(bus.err_code), 0);
        check("rst_wr_en",     32'(bus.lut_wr_en), 0);
        check("rst_wr_addr",   32'(bus.lut_wr_addr), 0);
        rst = 1'b0;
        tick();

        // ---- Valid load into bank 1, swap 10 cycles later ----
        snap();
        send(256, 1'b1, -1, 255, -1, 8'hFF, 1'b1);
        check("valid_load_done", 32'(bus.load_done), 1);
        check("valid_pending",   32'(bus.swap_pending), 1);
        check("valid_last_addr", 32'(bus.lut_wr_addr), 32'h1FF);
        check("valid_last_data", 32'(bus.lut_wr_data), 32'h00);
        repeat (10) tick();
        check("valid_wr_cnt",    32'(wr_cnt - b_wr), 256);
        check("valid_wr_hi",     32'(wr_hi_cnt - b_hi), 256);
        check("valid_done_cnt",  32'(done_cnt - b_done), 1);
        check("valid_hold_pend", 32'(bus.swap_pending), 1);
        check("valid_hold_bank", 32'(bus.rd_bank), 0);
        pulse_sof();
        check("swap_rd_bank",    32'(bus.rd_bank), 1);
        check("swap_done",       32'(bus.swap_done), 1);
        check("swap_pend_clr",   32'(bus.swap_pending), 0);
        tick();
        check("swap_cnt",        32'(swap_cnt - b_swap), 1);
        check("mem_263",         32'(mem[263]), 32'hF8);
        check("mem_456",         32'(mem[456]), 32'h37);

        // ---- Short packet: EOP on byte 100 (shadow is bank 0) ----
        snap();
        send(101, 1'b1, -1, 100, -1, 8'h55, 1'b0);
        check("short_err",      32'(bus.load_err), 1);
        check("short_code",     32'(bus.err_code), 1);
        check("short_busy",     32'(bus.load_busy), 0);
        check("short_pending",  32'(bus.swap_pending), 0);
        tick();
        pulse_sof();
        tick();
        check("short_wr_cnt",   32'(wr_cnt - b_wr), 101);
        check("short_no_done",  32'(done_cnt - b_done), 0);
        check("short_no_swap",  32'(swap_cnt - b_swap), 0);
        check("short_rd_bank",  32'(bus.rd_bank), 1);

        // ---- Long packet: 300 bytes ----
        snap();
        send(300, 1'b1, -1, 299, -1, 8'h00, 1'b0);
        check("long_code",      32'(bus.err_code), 2);
        check("long_busy",      32'(bus.load_busy), 0);
        tick();
        pulse_sof();
        tick();
        check("long_wr_cnt",    32'(wr_cnt - b_wr), 256);
        check("long_err_cnt",   32'(err_cnt - b_err), 1);
        check("long_no_done",   32'(done_cnt - b_done), 0);
        check("long_no_swap",   32'(swap_cnt - b_swap), 0);
        check("long_rd_bank",   32'(bus.rd_bank), 1);

        // ---- Restart at byte 50, then full table ----
        snap();
        send(306, 1'b1, 50, 305, -1, 8'h3C, 1'b0);
        check("restart_code",   32'(bus.err_code), 3);
        check("restart_done",   32'(bus.load_done), 1);
        check("restart_addr",   32'(bus.lut_wr_addr), 32'h0FF);
        tick();
        check("restart_err_cnt", 32'(err_cnt - b_err), 1);
        check("restart_wr_cnt", 32'(wr_cnt - b_wr), 306);

        // ---- Replacement while PENDING: second table wins ----
        send(256, 1'b1, -1, 255, -1, 8'hA5, 1'b0);
        check("repl_done",      32'(bus.load_done), 1);
        tick();
        pulse_sof();
        check("repl_rd_bank",   32'(bus.rd_bank), 0);
        check("repl_swap",      32'(bus.swap_done), 1);
        tick();
        check("repl_done_cnt",  32'(done_cnt - b_done), 2);
        check("repl_swap_cnt",  32'(swap_cnt - b_swap), 1);
        check("repl_mem_10",    32'(mem[10]),  32'hAF);
        check("repl_mem_100",   32'(mem[100]), 32'hC1);
        check("repl_mem_255",   32'(mem[255]), 32'h5A);

        // ---- EOP coincident with frame_sof: swap waits a frame ----
        send(256, 1'b1, -1, 255, 255, 8'h11, 1'b1);
        check("coin_eop_done",  32'(bus.load_done), 1);
        check("coin_eop_noswp", 32'(bus.swap_done), 0);
        check("coin_eop_bank",  32'(bus.rd_bank), 0);
        check("coin_eop_pend",  32'(bus.swap_pending), 1);
        tick();
        pulse_sof();
        check("coin_eop_swap",  32'(bus.swap_done), 1);
        check("coin_eop_bank2", 32'(bus.rd_bank), 1);

        // ---- SOP coincident with frame_sof in PENDING: no swap ----
        send(256, 1'b1, -1, 255, -1, 8'h22, 1'b0);
        tick();
        check("coin_sop_pend",  32'(bus.swap_pending), 1);
        bus.pkt_vld = 1'b1; bus.pkt_sop = 1'b1; bus.frame_sof = 1'b1; bus.pkt_data = 8'h99;
        tick();
        idle_inputs();
        check("coin_sop_noswp", 32'(bus.swap_done), 0);
        check("coin_sop_bank",  32'(bus.rd_bank), 1);
        check("coin_sop_pend0", 32'(bus.swap_pending), 0);
        check("coin_sop_busy",  32'(bus.load_busy), 1);
        check("coin_sop_addr",  32'(bus.lut_wr_addr), 32'h000);
        check("coin_sop_data",  32'(bus.lut_wr_data), 32'h99);

        // ---- Continue that load to byte 127, reset at byte 128 ----
        send(127, 1'b0, -1, -1, -1, 8'h00, 1'b0);
        check("mid_busy",       32'(bus.load_busy), 1);
        check("mid_addr",       32'(bus.lut_wr_addr), 32'h07F);
        bus.pkt_vld = 1'b1; bus.pkt_data = 8'h80;
        rst = 1'b1;
        tick();
        idle_inputs();
        check("mrst_rd_bank",   32'(bus.rd_bank), 0);
        check("mrst_busy",      32'(bus.load_busy), 0);
        check("mrst_pending",   32'(bus.swap_pending), 0);
        check("mrst_wr_en",     32'(bus.lut_wr_en), 0);
        check("mrst_wr_addr",   32'(bus.lut_wr_addr), 0);
        check("mrst_wr_data",   32'(bus.lut_wr_data), 0);
        check("mrst_done",      32'(bus.load_done), 0);
        check("mrst_swap",      32'(bus.swap_done), 0);
        check("mrst_err",       32'(bus.load_err), 0);
        check("mrst_code",      32'(bus.err_code), 0);
        rst = 1'b0;
        tick();

        // ---- Load after reset targets bank 1 ----
        snap();
        send(256, 1'b1, -1, 255, -1, 8'h44, 1'b1);
        check("post_done",      32'(bus.load_done), 1);
        check("post_addr",      32'(bus.lut_wr_addr), 32'h1FF);
        tick();
        check("post_wr_cnt",    32'(wr_cnt - b_wr), 256);
        check("post_wr_hi",     32'(wr_hi_cnt - b_hi), 256);
        pulse_sof();
        check("post_rd_bank",   32'(bus.rd_bank), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
